// File: rtl/can_fd_crc_field_rx_pkg.sv
// Shared definitions for the CAN FD CRC-field receiver: FSM state encoding,
// field lengths and the default fixed-stuff-bit spacing.
package can_fd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SC   = 2'd1,
    ST_CRC  = 2'd2
  } state_e;

  localparam int CRC17_LEN      = 17;
  localparam int CRC21_LEN      = 21;
  localparam int SC_LEN         = 4;
  localparam int FSB_PERIOD_DEF = 5;

endpackage

// File: rtl/can_fd_crc_field_rx_stuff_cnt_dec.sv
// Stuff-count decoder: three Gray bits (MSB first) plus one parity bit,
// giving the binary stuff count and an odd-parity error flag.
module can_stuff_cnt_dec (
  input  logic [3:0] sc_bits,
  output logic [2:0] stuff_cnt,
  output logic       parity_err
);

  // sc_bits[3:1] hold the Gray code in arrival order, sc_bits[0] is parity
  assign stuff_cnt[2] = sc_bits[3];
  assign stuff_cnt[1] = sc_bits[3] ^ sc_bits[2];
  assign stuff_cnt[0] = sc_bits[3] ^ sc_bits[2] ^ sc_bits[1];
  assign parity_err   = ^sc_bits;

endmodule

// File: rtl/can_fd_crc_field_rx.sv
// CAN FD CRC-field receiver: checks fixed stuff bits, destuffs the CRC and,
// when CAN_FD_STUFF_CNT_EN is defined, decodes the ISO stuff-count field.
module can_fd_crc_field_rx
  import can_fd_pkg::*;
#(
  parameter int CRC_MAX_W  = 21,
  parameter int FSB_PERIOD = FSB_PERIOD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 fd_iso,
  input  logic                 crc21_sel,
  output logic [CRC_MAX_W-1:0] crc_o,
  output logic [2:0]           stuff_cnt_o,
  output logic                 parity_err,
  output logic                 fsb_err_p,
  output logic                 fsb_err,
  output logic                 busy,
  output logic                 done
);

  localparam logic [6:0] FSB_P = 7'(FSB_PERIOD);

  state_e               state_q, state_d;
  logic [6:0]           pos_q, pos_d;
  logic [4:0]           dcnt_q, dcnt_d;
  logic [CRC_MAX_W-1:0] crc_q, crc_d;
  logic                 crc21_q, crc21_d;
  logic                 prev_q, prev_d;
  logic                 fsb_err_q, fsb_err_d;
  logic                 fsb_err_p_q, fsb_err_p_d;
  logic                 fin_q, fin_d;
  logic                 done_q, done_d;
  logic                 is_fsb;
  logic [4:0]           crc_last;

`ifdef CAN_FD_STUFF_CNT_EN
  logic [3:0] sc_q, sc_d;

  can_stuff_cnt_dec u_sc_dec (
    .sc_bits    (sc_q),
    .stuff_cnt  (stuff_cnt_o),
    .parity_err (parity_err)
  );
`else
  logic unused_fd_iso;
  assign unused_fd_iso = fd_iso;
  assign stuff_cnt_o   = 3'd0;
  assign parity_err    = 1'b0;
`endif

  assign is_fsb   = (pos_q % FSB_P) == 7'd0;
  assign crc_last = crc21_q ? 5'(CRC21_LEN - 1) : 5'(CRC17_LEN - 1);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dcnt_d      = dcnt_q;
    crc_d       = crc_q;
    crc21_d     = crc21_q;
    prev_d      = bit_valid ? bit_in : prev_q;
    fsb_err_d   = fsb_err_q;
    fsb_err_p_d = 1'b0;
    fin_d       = 1'b0;
    done_d      = fin_q;
`ifdef CAN_FD_STUFF_CNT_EN
    sc_d        = sc_q;
`endif
    if (abort) begin
      state_d = ST_IDLE;
    end else if (bit_valid && start) begin
      // Start bit is field position 0 and is itself the first FSB
      crc_d       = '0;
      crc21_d     = crc21_sel;
      dcnt_d      = 5'd0;
      pos_d       = 7'd1;
      fsb_err_d   = (bit_in == prev_q);
      fsb_err_p_d = (bit_in == prev_q);
`ifdef CAN_FD_STUFF_CNT_EN
      sc_d        = 4'd0;
      state_d     = fd_iso ? ST_SC : ST_CRC;
`else
      state_d     = ST_CRC;
`endif
    end else if (bit_valid && (state_q != ST_IDLE)) begin
      pos_d = pos_q + 7'd1;
      if (is_fsb) begin
        if (bit_in == prev_q) begin
          fsb_err_d   = 1'b1;
          fsb_err_p_d = 1'b1;
        end
      end else begin
        dcnt_d = dcnt_q + 5'd1;
        case (state_q)
`ifdef CAN_FD_STUFF_CNT_EN
          ST_SC: begin
            sc_d = {sc_q[2:0], bit_in};
            if (dcnt_q == 5'(SC_LEN - 1)) begin
              state_d = ST_CRC;
              dcnt_d  = 5'd0;
            end
          end
`endif
          ST_CRC: begin
            crc_d = {crc_q[CRC_MAX_W-2:0], bit_in};
            if (dcnt_q == crc_last) begin
              state_d = ST_IDLE;
              fin_d   = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= 7'd0;
      dcnt_q      <= 5'd0;
      crc_q       <= '0;
      crc21_q     <= 1'b0;
      prev_q      <= 1'b1;
      fsb_err_q   <= 1'b0;
      fsb_err_p_q <= 1'b0;
      fin_q       <= 1'b0;
      done_q      <= 1'b0;
`ifdef CAN_FD_STUFF_CNT_EN
      sc_q        <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dcnt_q      <= dcnt_d;
      crc_q       <= crc_d;
      crc21_q     <= crc21_d;
      prev_q      <= prev_d;
      fsb_err_q   <= fsb_err_d;
      fsb_err_p_q <= fsb_err_p_d;
      fin_q       <= fin_d;
      done_q      <= done_d;
`ifdef CAN_FD_STUFF_CNT_EN
      sc_q        <= sc_d;
`endif
    end
  end

  assign crc_o     = crc_q;
  assign fsb_err   = fsb_err_q;
  assign fsb_err_p = fsb_err_p_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_can_fd_crc_field_rx.sv
// Directed bench for can_fd_crc_field_rx; ISO scenarios adapt to whether
// CAN_FD_STUFF_CNT_EN is defined for the build.
module tb_can_fd_crc_field_rx;

  localparam int CW = 21;

  logic          clk = 1'b0;
  logic          rst, bit_valid, bit_in, start, abort, fd_iso, crc21_sel;
  logic [CW-1:0] crc_o;
  logic [2:0]    stuff_cnt_o;
  logic          parity_err, fsb_err_p, fsb_err, busy, done;

  int checks = 0, errors = 0, done_cnt = 0, fsbp_cnt = 0;
  bit fb[$];

  can_fd_crc_field_rx #(.CRC_MAX_W(CW), .FSB_PERIOD(5)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .start(start), .abort(abort), .fd_iso(fd_iso), .crc21_sel(crc21_sel),
    .crc_o(crc_o), .stuff_cnt_o(stuff_cnt_o), .parity_err(parity_err),
    .fsb_err_p(fsb_err_p), .fsb_err(fsb_err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (fsb_err_p) fsbp_cnt++;
  end

  task automatic tick();
    bit_valid = 1'b0; start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input bit b, input bit st, input bit ab);
    bit_valid = 1'b1; bit_in = b; start = st; abort = ab;
    @(posedge clk); #1;
    bit_valid = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  // Field bits with a complementing FSB at every 5th position, MSB-first data
  task automatic build(input logic [24:0] data, input int n, input bit prv);
    bit lastb, b;
    int k, p;
    fb.delete();
    lastb = prv; k = n - 1; p = 0;
    while (k >= 0) begin
      if (p % 5 == 0) b = ~lastb;
      else begin b = data[k]; k--; end
      fb.push_back(b);
      lastb = b;
      p++;
    end
  endtask

  task automatic send_fb(input int from, input int to, input int abort_at);
    for (int i = from; i <= to; i++) send_bit(fb[i], i == 0, i == abort_at);
  endtask

  task automatic test_reset();
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; start = 1'b0; abort = 1'b0;
    fd_iso = 1'b0; crc21_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (crc_o !== '0) begin errors++; $display("FAIL reset_crc: got %h expected 0", crc_o); end
    checks++; if (stuff_cnt_o !== 3'd0 || parity_err !== 1'b0) begin errors++; $display("FAIL reset_sc: got %0d/%b expected 0/0", stuff_cnt_o, parity_err); end
    checks++; if ({fsb_err, fsb_err_p, busy, done} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {fsb_err, fsb_err_p, busy, done}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_iso_crc17();
    int d0;
    send_bit(1'b0, 1'b0, 1'b0);
    fd_iso = 1'b1; crc21_sel = 1'b0;
`ifdef CAN_FD_STUFF_CNT_EN
    build({3'b110, 1'b0, 17'h1A5C3}, 21, 1'b0);
`else
    build({4'b0, 17'h1A5C3}, 17, 1'b0);
`endif
    d0 = done_cnt;
    send_fb(0, fb.size() - 2, -1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL iso17_busy_before_last: got %b expected 1", busy); end
    send_fb(fb.size() - 1, fb.size() - 1, -1);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL iso17_capture_edge: got busy %b done %b expected 0 0", busy, done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL iso17_done: got %b expected 1", done); end
    tick();
    checks++; if (done !== 1'b0 || done_cnt !== d0 + 1) begin errors++; $display("FAIL iso17_done_pulse: got done %b count %0d expected 0 %0d", done, done_cnt - d0, 1); end
    checks++; if (crc_o !== 21'h1A5C3) begin errors++; $display("FAIL iso17_crc: got %h expected 1a5c3", crc_o); end
`ifdef CAN_FD_STUFF_CNT_EN
    checks++; if (stuff_cnt_o !== 3'd4 || parity_err !== 1'b0) begin errors++; $display("FAIL iso17_sc: got %0d/%b expected 4/0", stuff_cnt_o, parity_err); end
`else
    checks++; if (stuff_cnt_o !== 3'd0 || parity_err !== 1'b0) begin errors++; $display("FAIL iso17_sc: got %0d/%b expected 0/0", stuff_cnt_o, parity_err); end
`endif
    checks++; if (fsb_err !== 1'b0) begin errors++; $display("FAIL iso17_fsb_err: got %b expected 0", fsb_err); end
  endtask

  task automatic test_noniso_crc21();
    int d0;
    fd_iso = 1'b0; crc21_sel = 1'b1;
    build({4'b0, 21'h12AB3F}, 21, fb[fb.size() - 1]);
    d0 = done_cnt;
    send_fb(0, 25, -1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ni21_busy_before_last: got %b expected 1", busy); end
    send_fb(26, 26, -1);
    tick(); tick();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL ni21_done: got %0d pulses expected 1", done_cnt - d0); end
    checks++; if (crc_o !== 21'h12AB3F) begin errors++; $display("FAIL ni21_crc: got %h expected 12ab3f", crc_o); end
    checks++; if (stuff_cnt_o !== 3'd0 || fsb_err !== 1'b0) begin errors++; $display("FAIL ni21_sc_err: got %0d/%b expected 0/0", stuff_cnt_o, fsb_err); end
  endtask

  task automatic test_fsb_err();
    int d0, f0, last;
    crc21_sel = 1'b1;
`ifdef CAN_FD_STUFF_CNT_EN
    fd_iso = 1'b1;
    build({4'b0110, 21'h12AB3F}, 25, fb[fb.size() - 1]);
`else
    fd_iso = 1'b0;
    build({4'b0, 21'h12AB3F}, 21, fb[fb.size() - 1]);
`endif
    fb[10] = fb[9];
    last = fb.size() - 1;
    d0 = done_cnt; f0 = fsbp_cnt;
    send_fb(0, 10, -1);
    checks++; if (fsb_err_p !== 1'b1 || fsb_err !== 1'b1) begin errors++; $display("FAIL fsb_err_at10: got p %b sticky %b expected 1 1", fsb_err_p, fsb_err); end
    send_fb(11, last - 1, -1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fsb_busy_before_last: got %b expected 1", busy); end
    send_fb(last, last, -1);
    tick(); tick();
    checks++; if (fsbp_cnt !== f0 + 1 || fsb_err !== 1'b1) begin errors++; $display("FAIL fsb_err_sticky: got %0d pulses sticky %b expected 1 1", fsbp_cnt - f0, fsb_err); end
    checks++; if (crc_o !== 21'h12AB3F || done_cnt !== d0 + 1) begin errors++; $display("FAIL fsb_crc_done: got %h/%0d expected 12ab3f/1", crc_o, done_cnt - d0); end
`ifdef CAN_FD_STUFF_CNT_EN
    checks++; if (stuff_cnt_o !== 3'd2 || parity_err !== 1'b0) begin errors++; $display("FAIL sc_0110: got %0d/%b expected 2/0", stuff_cnt_o, parity_err); end
`endif
  endtask

  task automatic test_parity();
`ifdef CAN_FD_STUFF_CNT_EN
    fd_iso = 1'b1; crc21_sel = 1'b0;
    build({4'b0111, 17'h00000}, 21, fb[fb.size() - 1]);
    send_fb(0, fb.size() - 1, -1);
    tick(); tick();
    checks++; if (parity_err !== 1'b1 || stuff_cnt_o !== 3'd2) begin errors++; $display("FAIL sc_0111: got %b/%0d expected 1/2", parity_err, stuff_cnt_o); end
    checks++; if (fsb_err !== 1'b0) begin errors++; $display("FAIL sc_0111_fsb: got %b expected 0", fsb_err); end
`endif
  endtask

  task automatic test_abort();
    int d0;
    bit lastb;
    fd_iso = 1'b0; crc21_sel = 1'b0;
    build({8'b0, 17'h0F0F0}, 17, fb[fb.size() - 1]);
    d0 = done_cnt;
    send_fb(0, 12, 12);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    lastb = fb[12];
    build({8'b0, 17'h15A5A}, 17, lastb);
    send_fb(0, fb.size() - 1, -1);
    tick(); tick();
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (crc_o !== 21'h15A5A || fsb_err !== 1'b0) begin errors++; $display("FAIL abort_second_field: got %h/%b expected 15a5a/0", crc_o, fsb_err); end
  endtask

  task automatic test_restart_and_ignore();
    int d0;
    bit lastb;
    fd_iso = 1'b0; crc21_sel = 1'b1;
    build({4'b0, 21'h1FFFFF}, 21, fb[fb.size() - 1]);
    d0 = done_cnt;
    send_fb(0, 7, -1);
    lastb = fb[7];
    crc21_sel = 1'b0;
    build({8'b0, 17'h0ACE1}, 17, lastb);
    send_fb(0, 0, -1);
    checks++; if (crc_o !== '0 || busy !== 1'b1) begin errors++; $display("FAIL restart_clear: got %h busy %b expected 0 1", crc_o, busy); end
    send_fb(1, fb.size() - 1, -1);
    tick(); tick();
    checks++; if (crc_o !== 21'h0ACE1 || done_cnt !== d0 + 1) begin errors++; $display("FAIL restart_field: got %h/%0d expected 0ace1/1", crc_o, done_cnt - d0); end
    bit_valid = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_no_valid: got busy %b expected 0", busy); end
  endtask

  task automatic test_rst_mid();
    fd_iso = 1'b0; crc21_sel = 1'b0;
    build({8'b0, 17'h1E000}, 17, fb[fb.size() - 1]);
    fb[5] = fb[4];
    send_fb(0, 8, -1);
    checks++; if (busy !== 1'b1 || fsb_err !== 1'b1 || crc_o !== 21'h78) begin errors++; $display("FAIL rst_pre: got busy %b err %b crc %h expected 1 1 78", busy, fsb_err, crc_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({busy, fsb_err, fsb_err_p, done} !== 4'b0 || crc_o !== '0 || stuff_cnt_o !== 3'd0 || parity_err !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs: got %b crc %h sc %0d expected all 0", {busy, fsb_err, fsb_err_p, done}, crc_o, stuff_cnt_o); end
    build({8'b0, 17'h0BEEF}, 17, 1'b1);
    send_fb(0, fb.size() - 1, -1);
    tick(); tick();
    checks++; if (fsb_err !== 1'b0 || crc_o !== 21'h0BEEF) begin errors++; $display("FAIL rst_prev_one: got err %b crc %h expected 0 0beef", fsb_err, crc_o); end
  endtask

  initial begin
    test_reset();
    test_iso_crc17();
    test_noniso_crc21();
    test_fsb_err();
    test_parity();
    test_abort();
    test_restart_and_ignore();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_fd_crc_field_rx.md
CAN_FD_CRC_FIELD_RX -- requirements
Module: can_fd_crc_field_rx

Interface
REQ-001 Parameter CRC_MAX_W, default 21: width of crc_o; SHALL be >= 21.
REQ-002 Parameter FSB_PERIOD, default 5: field-bit spacing of fixed stuff bits (FSBs). One FSB is followed by FSB_PERIOD-1 data bits.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 bit_valid  in  1  sample-point strobe; bit_in qualified only when high.
REQ-006 bit_in  in  1  received bit.
REQ-007 start  in  1  the current bit_valid bit is field bit 0, which is the first FSB.
REQ-008 abort  in  1  drop the field in progress.
REQ-009 fd_iso  in  1  1 = ISO field (stuff count plus CRC); 0 = non-ISO (CRC only); sampled at start.
REQ-010 crc21_sel  in  1  1 = CRC-21, 0 = CRC-17; sampled at start.
REQ-011 crc_o  out  CRC_MAX_W  destuffed CRC, right-aligned, upper bits zero.
REQ-012 stuff_cnt_o  out  3  binary-decoded stuff count.
REQ-013 parity_err  out  1  stuff-count parity error, sticky per field.
REQ-014 fsb_err_p  out  1  one-cycle pulse on an FSB error.
REQ-015 fsb_err  out  1  sticky FSB error, cleared at start.
REQ-016 busy  out  1  high in states SC and CRC.
REQ-017 done  out  1  one-cycle pulse when the field is complete.

Function
REQ-018 prev_bit register SHALL load bit_in on every bit_valid in all states; reset value 1.
REQ-019 States SHALL be IDLE, SC and CRC. Only a bit_valid cycle advances field state.
REQ-020 Transitions:
- IDLE -> SC on start&bit_valid with fd_iso=1.
- IDLE -> CRC on start&bit_valid with fd_iso=0.
- SC -> CRC after the 4th stuff-count data bit.
- CRC -> IDLE after the last CRC data bit, with done the next cycle.
REQ-021 Field position counter pos SHALL be 0 at the start bit and increment per bit_valid. Bit pos is an FSB when pos mod FSB_PERIOD == 0; otherwise it is a data bit.
REQ-022 FSB check: fsb_err_p = 1 and fsb_err set when an FSB equals prev_bit. FSBs are never shifted into the data path. Reception continues after an error.
REQ-023 Data-bit count per field:
- ISO: 4 + N.
- Non-ISO: N.
- N = 21 if crc21_sel, else 17.
- Default-period totals including FSBs: ISO 27/32, non-ISO 22/27.
REQ-024 SC data bits are 3 Gray bits (MSB first) then a parity bit. stuff_cnt_o = Gray-to-binary of the 3 Gray bits. parity_err = XOR of all 4 bits.
REQ-025 CRC data bits SHALL shift into crc_o LSB-side, MSB first. crc_o is cleared to 0 at start.
REQ-026 done SHALL pulse one clk after the edge that captures the final CRC bit. crc_o, stuff_cnt_o and error flags hold until the next start or rst.
REQ-027 start while busy restarts the field; outputs are cleared as at start, and no done is issued for the aborted field.
REQ-028 abort returns to IDLE with no done. abort has priority over a simultaneous start.
REQ-029 bit_valid low with start high SHALL be ignored.

Reset
REQ-030 On rst, all outputs SHALL be 0, state SHALL be IDLE, pos SHALL be 0, and prev_bit SHALL be 1.

Configuration
REQ-031 Macro CAN_FD_STUFF_CNT_EN:
- Defined: ISO stuff-count path as specified.
- Undefined: fd_iso is treated as 0, state SC is absent, and stuff_cnt_o and parity_err are constant 0.

Structure
REQ-032 Package can_fd_pkg SHALL hold:
- the state enum;
- CRC17_LEN = 17, CRC21_LEN = 21, SC_LEN = 4;
- default FSB_PERIOD.
REQ-033 Sub-module can_stuff_cnt_dec: Gray-to-binary conversion plus parity check. It is instantiated only under CAN_FD_STUFF_CNT_EN.

Verification
REQ-034 ISO, CRC-17, prev_bit = 0, correct FSBs, SC Gray 110 parity 0, CRC 0x1A5C3 -> done after the 27th bit, crc_o = 0x1A5C3, stuff_cnt_o = 4, no errors.
REQ-035 Non-ISO, CRC-21 = 0x12AB3F -> done after the 27th bit, crc_o = 0x12AB3F, stuff_cnt_o = 0.
REQ-036 ISO CRC-21, FSB at pos 10 equals the preceding bit -> fsb_err_p pulses once, fsb_err stays 1, crc_o still correct, done after the 32nd bit.
REQ-037 SC bits 0110 -> parity_err = 0; SC bits 0111 -> parity_err = 1.
REQ-038 abort at pos 12, then start at the next bit -> no done for the first field; the second field completes normally.
REQ-039 rst asserted at pos 8, and a build without CAN_FD_STUFF_CNT_EN with fd_iso = 1 -> all outputs return to 0; non-ISO totals of 22/27 bits apply.
